// File: rtl/level_select_ctrl_if.sv
// Button-in / level-out bundle between the board pushbuttons and the level selector.
// The display driver and the audio parameter path take their values from the slave side.
interface level_select_ctrl_if;
   logic       btnUp_n;
   logic       btnDown_n;
   logic [3:0] levelValue;
   logic       levelChanged;

   modport master (
      output btnUp_n,
      output btnDown_n,
      input  levelValue,
      input  levelChanged
   );

   modport slave (
      input  btnUp_n,
      input  btnDown_n,
      output levelValue,
      output levelChanged
   );
endinterface

// File: rtl/level_select_ctrl.sv
// Up/down pushbutton level selector: sync, debounce, single step on press, auto-repeat on hold.
// Produces a saturating or wrapping 4-bit level plus a one-cycle change strobe.
module level_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int MAX_VALUE       = 15,
   parameter int RESET_VALUE     = 0,
   parameter int WRAP            = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   level_select_ctrl_if.slave bus
);
   // state    | meaning
   // S_IDLE   | no repeat in progress, waiting for a single-button press edge
   // S_HOLD   | latched button held, counting REPEAT_DELAY before the first repeat
   // S_REPEAT | latched button still held, stepping every REPEAT_RATE clocks

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);
   localparam logic [3:0]       MAX_V   = 4'(MAX_VALUE);
   localparam logic [3:0]       RST_V   = 4'(RESET_VALUE);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

   // bit 0 = up, bit 1 = down throughout
   logic [1:0]      sync1, sync2;
   logic [1:0]      pressed, pressed_q;
   logic [DB_W-1:0] db_cnt [2];

   state_t           state;
   logic             dir_up;
   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_last;

   logic [1:0] press_edge;
   logic       start_up, start_dn;
   logic       held_ok, tick;
   logic       step_up, step_dn;

   logic [3:0] level;
   logic       changed;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= 2'b11;
         sync2     <= 2'b11;
         pressed   <= 2'b00;
         pressed_q <= 2'b00;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1     <= {bus.btnDown_n, bus.btnUp_n};
         sync2     <= sync1;
         pressed_q <= pressed;
         for (int i = 0; i < 2; i++) begin
            if ((~sync2[i]) != pressed[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  pressed[i] <= ~sync2[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // The repeat engine watches the latched button one stage late so that its
   // release lines up with the registered press-edge pulse; the other button is
   // watched undelayed so a second press cancels repeat at once.
   assign press_edge = pressed & ~pressed_q;
   assign start_up   = press_edge[0] & ~pressed[1];
   assign start_dn   = press_edge[1] & ~pressed[0];
   assign held_ok    = dir_up ? (pressed_q[0] & ~pressed[1]) : (pressed_q[1] & ~pressed[0]);
   assign rpt_last   = (state == S_HOLD) ? RD_LAST : RR_LAST;
   assign tick       = (state != S_IDLE) && held_ok && (rpt_cnt == rpt_last);
   assign step_up    = start_up | (tick & dir_up);
   assign step_dn    = start_dn | (tick & ~dir_up);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         dir_up  <= 1'b1;
         rpt_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               rpt_cnt <= '0;
               if (start_up) begin
                  dir_up <= 1'b1;
                  state  <= S_HOLD;
               end else if (start_dn) begin
                  dir_up <= 1'b0;
                  state  <= S_HOLD;
               end
            end
            S_HOLD, S_REPEAT: begin
               if (!held_ok) begin
                  state   <= S_IDLE;
                  rpt_cnt <= '0;
               end else if (rpt_cnt == rpt_last) begin
                  state   <= S_REPEAT;
                  rpt_cnt <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               rpt_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level   <= RST_V;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (step_up && !step_dn) begin
            if (level >= MAX_V) begin
               if (WRAP != 0) begin
                  level   <= 4'd0;
                  changed <= 1'b1;
               end
            end else begin
               level   <= level + 4'd1;
               changed <= 1'b1;
            end
         end else if (step_dn && !step_up) begin
            if (level == 4'd0) begin
               if (WRAP != 0) begin
                  level   <= MAX_V;
                  changed <= 1'b1;
               end
            end else begin
               level   <= level - 4'd1;
               changed <= 1'b1;
            end
         end
      end
   end

   assign bus.levelValue   = level;
   assign bus.levelChanged = changed;
endmodule

// File: tb/tb_level_select_ctrl.sv
// Directed bench for level_select_ctrl: a saturating (WRAP=0) and a wrapping (WRAP=1)
// instance fed identical buttons, checked against hand-computed levels and strobe counts.
module tb_level_select_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   level_select_ctrl_if if0 ();
   level_select_ctrl_if if1 ();

   level_select_ctrl #(
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5),
      .MAX_VALUE(15), .RESET_VALUE(0), .WRAP(0)
   ) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));

   level_select_ctrl #(
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5),
      .MAX_VALUE(15), .RESET_VALUE(0), .WRAP(1)
   ) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

   int total = 0;
   int bad = 0;
   int pulses0 = 0;
   int pulses1 = 0;
   int incons = 0;
   logic [3:0] prev0 = 4'd0;
   logic [3:0] prev1 = 4'd0;

   // strobe must be high exactly in the cycles where the level moved
   always @(negedge clk) begin
      if (reset_n) begin
         if (if0.levelChanged) pulses0++;
         if (if1.levelChanged) pulses1++;
         if (if0.levelChanged !== (if0.levelValue != prev0)) incons++;
         if (if1.levelChanged !== (if1.levelValue != prev1)) incons++;
      end
      prev0 = if0.levelValue;
      prev1 = if1.levelValue;
   end

   typedef struct {
      logic  up_n;
      logic  dn_n;
      int    cycles;
      int    val0;
      int    val1;
      int    pul0;
      int    pul1;
      string name;
   } vec_t;

   vec_t vecs[$];

   task automatic set_btn(input logic u, input logic d);
      if0.btnUp_n   = u;
      if0.btnDown_n = d;
      if1.btnUp_n   = u;
      if1.btnDown_n = d;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
   endtask

   function automatic int rep_expect(input int k);
      int n;
      int m;
      n = 0;
      if (k >= 7) n = 1;
      if (k >= 27) begin
         m = (k - 27) / 5;
         if (m > 8) m = 8;
         n = n + 1 + m;
      end
      return n;
   endfunction

   initial begin
      int p0, p1;

      // after seq A both instances sit at 1
      vecs.push_back('{1'b1, 1'b0,  3, 1,  1, 0, 0, "glitch1_low"});
      vecs.push_back('{1'b1, 1'b1,  3, 1,  1, 0, 0, "glitch1_high"});
      vecs.push_back('{1'b1, 1'b0,  3, 1,  1, 0, 0, "glitch2_low"});
      vecs.push_back('{1'b1, 1'b1,  3, 1,  1, 0, 0, "glitch2_high"});
      vecs.push_back('{1'b1, 1'b0,  3, 1,  1, 0, 0, "glitch3_low"});
      vecs.push_back('{1'b1, 1'b1, 10, 1,  1, 0, 0, "glitch3_settle"});
      vecs.push_back('{1'b0, 1'b0, 40, 1,  1, 0, 0, "both_held"});
      vecs.push_back('{1'b1, 1'b1, 12, 1,  1, 0, 0, "both_release"});
      vecs.push_back('{1'b1, 1'b0, 10, 0,  0, 1, 1, "down_1to0"});
      vecs.push_back('{1'b1, 1'b1, 12, 0,  0, 0, 0, "down_release"});
      vecs.push_back('{1'b1, 1'b0, 10, 0, 15, 0, 1, "down_at_zero"});
      vecs.push_back('{1'b1, 1'b1, 12, 0, 15, 0, 0, "down_zero_release"});
      vecs.push_back('{1'b0, 1'b1, 10, 1,  0, 1, 1, "up_wrap_top"});
      vecs.push_back('{1'b1, 1'b1, 12, 1,  0, 0, 0, "up_wrap_release"});

      set_btn(1'b1, 1'b1);
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      chk("reset_val0", if0.levelValue, 0);
      chk("reset_chg0", if0.levelChanged, 0);
      chk("reset_val1", if1.levelValue, 0);

      // A: single clean press, 7-clock latency, one strobe
      p0 = pulses0;
      set_btn(1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (k == 6) chk("lat_before", if0.levelValue, 0);
         if (k == 7) begin
            chk("lat_val", if0.levelValue, 1);
            chk("lat_chg", if0.levelChanged, 1);
         end
         if (k == 8) chk("lat_chg_one_cycle", if0.levelChanged, 0);
      end
      set_btn(1'b1, 1'b1);
      tick(12);
      chk("press_final0", if0.levelValue, 1);
      chk("press_final1", if1.levelValue, 1);
      chk("press_pulses", pulses0 - p0, 1);

      // table of held-level segments
      for (int v = 0; v < vecs.size(); v++) begin
         p0 = pulses0;
         p1 = pulses1;
         set_btn(vecs[v].up_n, vecs[v].dn_n);
         tick(vecs[v].cycles);
         chk({vecs[v].name, "_val0"}, if0.levelValue, vecs[v].val0);
         chk({vecs[v].name, "_val1"}, if1.levelValue, vecs[v].val1);
         chk({vecs[v].name, "_pul0"}, pulses0 - p0, vecs[v].pul0);
         chk({vecs[v].name, "_pul1"}, pulses1 - p1, vecs[v].pul1);
      end

      // C: hold up for 60 clocks from 0, steps at +7, +27, then every 5
      do_reset();
      chk("rep_reset", if0.levelValue, 0);
      p0 = pulses0;
      set_btn(1'b0, 1'b1);
      for (int k = 1; k <= 75; k++) begin
         tick(1);
         if (k == 60) set_btn(1'b1, 1'b1);
         chk($sformatf("rep_k%0d", k), if0.levelValue, rep_expect(k));
      end
      chk("rep_pulses", pulses0 - p0, 10);

      // D: saturate at 15 under repeat, then a single press at the top
      p0 = pulses0;
      set_btn(1'b0, 1'b1);
      tick(60);
      set_btn(1'b1, 1'b1);
      tick(12);
      chk("sat_rep_val", if0.levelValue, 15);
      chk("sat_rep_pulses", pulses0 - p0, 5);
      p0 = pulses0;
      set_btn(1'b0, 1'b1);
      tick(10);
      set_btn(1'b1, 1'b1);
      tick(12);
      chk("sat_press_val", if0.levelValue, 15);
      chk("sat_press_pulses", pulses0 - p0, 0);

      // E: up repeating, down pressed -> repeat cancelled on the very cycle it would step
      do_reset();
      p0 = pulses0;
      set_btn(1'b0, 1'b1);
      tick(30);
      chk("cancel_pre", if0.levelValue, 2);
      set_btn(1'b0, 1'b0);
      for (int k = 31; k <= 70; k++) begin
         tick(1);
         if (k == 37) chk("cancel_k37", if0.levelValue, 3);
      end
      chk("cancel_frozen", if0.levelValue, 3);
      set_btn(1'b1, 1'b1);
      tick(12);
      chk("cancel_release", if0.levelValue, 3);
      chk("cancel_pulses", pulses0 - p0, 3);

      // F: async reset mid-repeat with up still held
      do_reset();
      set_btn(1'b0, 1'b1);
      tick(64);
      chk("mid_rep_val", if0.levelValue, 9);
      reset_n = 1'b0;
      #1;
      chk("async_reset_val", if0.levelValue, 0);
      chk("async_reset_chg", if0.levelChanged, 0);
      tick(2);
      reset_n = 1'b1;
      for (int k = 1; k <= 27; k++) begin
         tick(1);
         if (k == 6)  chk("rst_k6", if0.levelValue, 0);
         if (k == 7)  chk("rst_k7", if0.levelValue, 1);
         if (k == 26) chk("rst_k26", if0.levelValue, 1);
         if (k == 27) chk("rst_k27", if0.levelValue, 2);
      end
      set_btn(1'b1, 1'b1);
      tick(12);

      chk("strobe_consistency", incons, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/level_select_ctrl.md
Name: level_select_ctrl

Overview:
- Upstream stage of the two-digit seven-segment display driver: converts two raw board pushbuttons (up/down) into a registered 4-bit effect-level value, 0..MAX_VALUE, which that driver splits into tens/units digits.
- Provides input synchronisation, debouncing, single-step on press, and auto-repeat on hold.
- Also emits a one-cycle change strobe for the audio effect parameter path.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clocks a synchronised button level must persist before being accepted (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, clocks a button must stay held after its first step before auto-repeat starts.
- REPEAT_RATE, 5000000, clocks between auto-repeat steps.
- MAX_VALUE, 15, upper limit of levelValue; legal range 1..15.
- RESET_VALUE, 0, levelValue after reset; must be <= MAX_VALUE.
- WRAP, 0, 0 = saturate at limits, 1 = wrap MAX_VALUE<->0.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btnUp_n  input  1  raw up pushbutton, active-low, asynchronous to clk.
- btnDown_n  input  1  raw down pushbutton, active-low, asynchronous to clk.
- levelValue  output  4  registered level, to display driver inputValue.
- levelChanged  output  1  one-cycle pulse in the cycle levelValue takes a new value.

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - levelValue = RESET_VALUE, levelChanged = 0.
  - Synchronisers = 1 (released), debounced states = released, debounce and repeat counters = 0, FSM = IDLE.
  - Asserting reset mid-hold or mid-debounce abandons all progress. After release, a still-held button is treated as a new press once debounced.
- Synchroniser: two flops per button, reset to 1.
- Debounce, per button:
  - The counter increments each cycle the synchronised level differs from the debounced state, and clears on any cycle it matches.
  - The debounced state flips on the clock where the counter would reach DEBOUNCE_CYCLES; the counter clears at the same time.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Step request:
  - A step is a debounced press edge (released->pressed) or an auto-repeat tick.
  - An up step and a down step in the same cycle cancel: no change.
  - While both debounced buttons are pressed, no steps occur and the FSM holds in IDLE.
- Value update: registered, one cycle after the step request.
  - Up step: value+1. If value == MAX_VALUE, hold when WRAP=0, or go to 0 when WRAP=1.
  - Down step: value-1. If value == 0, hold when WRAP=0, or go to MAX_VALUE when WRAP=1.
  - levelChanged = 1 only when the new value differs from the old; a saturated step gives no pulse.
- End-to-end latency from a clean raw edge to the levelValue update: 2 sync + DEBOUNCE_CYCLES + 1 clocks.
- Auto-repeat FSM (a single repeat counter, shared by both buttons):
  - IDLE: on a debounced press edge of exactly one button, latch the direction, clear the counter, go to HOLD.
  - HOLD: count while the latched button stays pressed and the other stays released.
    - At count REPEAT_DELAY-1: issue a step, clear the counter, go to REPEAT.
  - REPEAT: issue a step every REPEAT_RATE cycles.
  - Leaving HOLD or REPEAT: debounced release of the latched button, or a press of the other button, returns to IDLE with no step that cycle.
- Output constraints:
  - levelValue never exceeds MAX_VALUE in any state.
  - Output widths are fixed at 4 bits regardless of parameters.

Test Plan (sim params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, MAX_VALUE=15, RESET_VALUE=0, WRAP=0):
- Reset, then one clean btnUp_n press held 10 cycles and released -> levelValue 0->1 exactly 7 clocks after the edge; one levelChanged pulse; value stays 1.
- Three 3-cycle low glitches on btnDown_n, with value at 1 -> no change, no levelChanged.
- btnUp_n held 60 cycles from 0 -> steps at press+7, then +20, then every 5 cycles; final value 10; one levelChanged pulse per step.
- Value at 15, up press -> stays 15, no levelChanged. Rerun with WRAP=1 -> 0 with a pulse. Value 0, down press with WRAP=1 -> 15.
- Both buttons pressed on the same cycle, held 40 cycles -> no change. Up held into REPEAT, then down pressed -> repeat stops, value frozen.
- reset_n pulsed low mid-REPEAT at value 9, with up still held -> levelValue=0 immediately (asynchronous). After release, the first step occurs 7 clocks later; the value then auto-repeats from 1.
